// File: rtl/alu_seq.sv
// Sequential execute-stage ALU with valid/ready handshake and HI/LO registers.
// Multiply and divide run one bit per cycle; all other ops complete in one cycle.
module alu_seq #(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] BAD_RESULT = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         operand_a,
    input  logic [WIDTH-1:0]         operand_b,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [5:0]               func,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         result,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_SRA   = 6'd3;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   q, dvsr;
    logic [SW-1:0]      cnt;
    logic               neg_q, neg_r;

    logic               accept, is_mul, is_div, b_zero, last;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b, alu_res;
    logic [2*WIDTH-1:0] acc_add, prod_fin;
    logic [WIDTH:0]     shl, diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt, q_nxt, quo_fin, rem_fin;

    always_comb begin
        in_ready  = (state == IDLE);
        accept    = in_valid && in_ready;
        is_mul    = (func == F_MULT) || (func == F_MULTU);
        is_div    = (func == F_DIV) || (func == F_DIVU);
        b_zero    = (operand_b == '0);
        last      = (cnt == SW'(WIDTH - 1));
        // even func codes (mult/div) are the signed variants
        sa        = !func[0] && operand_a[WIDTH-1];
        sb        = !func[0] && operand_b[WIDTH-1];
        mag_a     = sa ? -operand_a : operand_a;
        mag_b     = sb ? -operand_b : operand_b;
        acc_add   = acc + (q[0] ? mcand : '0);
        prod_fin  = neg_q ? -acc_add : acc_add;
        shl       = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff      = shl - {1'b0, dvsr};
        ge        = (shl >= {1'b0, dvsr});
        rem_nxt   = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
        q_nxt     = {q[WIDTH-2:0], ge};
        quo_fin   = neg_q ? -q_nxt : q_nxt;
        rem_fin   = neg_r ? -rem_nxt : rem_nxt;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mul)
                    state_nxt = MUL;
                else if (accept && is_div && !b_zero)
                    state_nxt = DIV;
            end
            MUL, DIV: begin
                if (last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_res = WIDTH'(BAD_RESULT);
        case (func)
            F_ADD:         alu_res = operand_a + operand_b;
            F_SUB:         alu_res = operand_a - operand_b;
            F_AND:         alu_res = operand_a & operand_b;
            F_OR:          alu_res = operand_a | operand_b;
            F_XOR:         alu_res = operand_a ^ operand_b;
            F_NOR:         alu_res = ~(operand_a | operand_b);
            F_SLL:         alu_res = operand_b << shamt;
            F_SRL:         alu_res = operand_b >> shamt;
            F_SRA:         alu_res = $signed(operand_b) >>> shamt;
            F_MFHI:        alu_res = hi;
            F_MFLO:        alu_res = lo;
            F_DIV, F_DIVU: alu_res = '1;
            default:       alu_res = WIDTH'(BAD_RESULT);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            q         <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, mag_a};
                        q     <= is_div ? mag_a : mag_b;
                        dvsr  <= mag_b;
                        cnt   <= '0;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        if (state_nxt == IDLE) begin
                            result    <= alu_res;
                            out_valid <= 1'b1;
                        end
                        if (is_div && b_zero) begin
                            hi <= operand_a;
                            lo <= '1;
                        end
                    end
                end
                MUL: begin
                    acc   <= acc_add;
                    mcand <= mcand << 1;
                    q     <= q >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        {hi, lo}  <= prod_fin;
                        result    <= prod_fin[WIDTH-1:0];
                        out_valid <= 1'b1;
                    end
                end
                DIV: begin
                    acc   <= {{WIDTH{1'b0}}, rem_nxt};
                    q     <= q_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        hi        <= rem_fin;
                        lo        <= quo_fin;
                        result    <= quo_fin;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq.
// Expected values are hand-computed MIPS ALU results.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH(32),
        .BAD_RESULT(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .shamt(shamt),
        .func(func),
        .out_valid(out_valid),
        .result(result),
        .hi(hi),
        .lo(lo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s);
        in_valid  = 1'b1;
        func      = f;
        operand_a = a;
        operand_b = b;
        shamt     = s;
    endtask

    // Request must already be driven; returns latency and in_ready-low cycles.
    task automatic run_long(output int lat, output int low);
        step();
        in_valid = 1'b0;
        lat = 1;
        low = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b1) low++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        func      = 6'd0;
        operand_a = '0;
        operand_b = '0;
        shamt     = '0;
        repeat (3) step();
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset result: got %h want %h", result, 32'h0);
        end
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset hilo: got %h/%h want 0/0", hi, lo);
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset flags: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [3];
        logic [5:0]  fs [3];
        logic [31:0] as [3];
        logic [31:0] bs [3];
        fs = '{6'd32, 6'd34, 6'd38};
        as = '{32'd7, 32'd3, 32'hF0F0F0F0};
        bs = '{32'd5, 32'd5, 32'h0FF00FF0};
        exp_r = '{32'd12, 32'hFFFFFFFE, 32'hFF00FF00};
        for (int i = 0; i < 3; i++) begin
            drive(fs[i], as[i], bs[i], 5'd0);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== exp_r[i]) begin
                n_fail++;
                $display("FAIL b2b op%0d: got ov=%b rdy=%b r=%h want 1 1 %h",
                         i, out_valid, in_ready, result, exp_r[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b idle out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_shifts();
        drive(6'd3, 32'h0, 32'h80000000, 5'd4);
        step();
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'hF8000000) begin
            n_fail++;
            $display("FAIL sra: got ov=%b r=%h want 1 %h", out_valid, result, 32'hF8000000);
        end
        drive(6'd2, 32'h0, 32'h80000000, 5'd4);
        step();
        n_checks++;
        if (result !== 32'h08000000) begin
            n_fail++;
            $display("FAIL srl: got %h want %h", result, 32'h08000000);
        end
        drive(6'd0, 32'h0, 32'h00000081, 5'd3);
        step();
        n_checks++;
        if (result !== 32'h00000408) begin
            n_fail++;
            $display("FAIL sll: got %h want %h", result, 32'h00000408);
        end
        drive(6'd39, 32'hF0F00000, 32'h0000000F, 5'd0);
        step();
        n_checks++;
        if (result !== 32'h0F0FFFF0) begin
            n_fail++;
            $display("FAIL nor: got %h want %h", result, 32'h0F0FFFF0);
        end
        drive(6'd1, 32'h12345678, 32'h9, 5'd0);
        step();
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL badfunc: got ov=%b r=%h want 1 %h", out_valid, result, 32'hDEADBEEF);
        end
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL badfunc hilo: got %h/%h want 0/0", hi, lo);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mult();
        int lat, low;
        drive(6'd24, 32'hFFFFFFFE, 32'h00000003, 5'd0);
        run_long(lat, low);
        n_checks++;
        if (lat !== 33 || low !== 32) begin
            n_fail++;
            $display("FAIL mult timing: got lat=%0d low=%0d want 33 32", lat, low);
        end
        n_checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA || result !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL mult: got hi=%h lo=%h r=%h want FFFFFFFF FFFFFFFA FFFFFFFA",
                     hi, lo, result);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mult pulse: got %b want 0", out_valid);
        end
        drive(6'd25, 32'hFFFFFFFE, 32'h00000003, 5'd0);
        run_long(lat, low);
        n_checks++;
        if (lat !== 33 || hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL multu: got lat=%0d hi=%h lo=%h want 33 00000002 FFFFFFFA",
                     lat, hi, lo);
        end
        step();
    endtask

    task automatic test_div();
        int lat, low;
        drive(6'd26, 32'hFFFFFFF9, 32'h00000002, 5'd0);
        run_long(lat, low);
        n_checks++;
        if (lat !== 33 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || result !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div -7/2: got lat=%0d lo=%h hi=%h r=%h want 33 FFFFFFFD FFFFFFFF FFFFFFFD",
                     lat, lo, hi, result);
        end
        step();
        drive(6'd27, 32'h00000007, 32'h0, 5'd0);
        run_long(lat, low);
        n_checks++;
        if (lat !== 1 || in_ready !== 1'b1 || lo !== 32'hFFFFFFFF || hi !== 32'h7 || result !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL divu by 0: got lat=%0d rdy=%b lo=%h hi=%h r=%h want 1 1 FFFFFFFF 7 FFFFFFFF",
                     lat, in_ready, lo, hi, result);
        end
        drive(6'd16, 32'h0, 32'h0, 5'd0);
        step();
        n_checks++;
        if (result !== 32'h7) begin
            n_fail++;
            $display("FAIL mfhi after div0: got %h want %h", result, 32'h7);
        end
        drive(6'd26, 32'h80000000, 32'hFFFFFFFF, 5'd0);
        run_long(lat, low);
        n_checks++;
        if (lat !== 33 || lo !== 32'h80000000 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL div minneg/-1: got lat=%0d lo=%h hi=%h want 33 80000000 0",
                     lat, lo, hi);
        end
        step();
        drive(6'd18, 32'h0, 32'h0, 5'd0);
        step();
        n_checks++;
        if (result !== 32'h80000000) begin
            n_fail++;
            $display("FAIL mflo: got %h want %h", result, 32'h80000000);
        end
        drive(6'd16, 32'h0, 32'h0, 5'd0);
        step();
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL mfhi: got %h want %h", result, 32'h0);
        end
        drive(6'd63, 32'h1, 32'h1, 5'd0);
        step();
        n_checks++;
        if (result !== 32'hDEADBEEF || lo !== 32'h80000000 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL badfunc keeps hilo: got r=%h lo=%h hi=%h want DEADBEEF 80000000 0",
                     result, lo, hi);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_hold_during_mult();
        int lat;
        drive(6'd25, 32'h3, 32'h4, 5'd0);
        step();
        drive(6'd32, 32'd100, 32'd1, 5'd0);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== 33 || result !== 32'd12 || lo !== 32'd12 || hi !== 32'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold mult: got lat=%0d r=%h lo=%h hi=%h rdy=%b want 33 c c 0 1",
                     lat, result, lo, hi, in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd101) begin
            n_fail++;
            $display("FAIL held add: got ov=%b r=%h want 1 %h", out_valid, result, 32'd101);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL held add single: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        int pulses;
        drive(6'd27, 32'd100, 32'd7, 5'd0);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || result !== 32'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid-div reset: got hi=%h lo=%h r=%h rdy=%b ov=%b want 0 0 0 1 0",
                     hi, lo, result, in_ready, out_valid);
        end
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL aborted div pulses: got %0d want 0", pulses);
        end
        drive(6'd32, 32'd2, 32'd3, 5'd0);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd5 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL add after reset: got ov=%b r=%h hi=%h lo=%h want 1 5 0 0",
                     out_valid, result, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shifts();
        test_mult();
        test_div();
        test_hold_during_mult();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the team's combinational ALU.
- Adds a valid/ready handshake, registered results, XOR/NOR/shift ops, and MIPS-style HI/LO registers.
- HI/LO are fed by an iterative multiplier (mult/multu) and an iterative restoring divider (div/divu).
- Sits in the execute stage; the pipeline stalls on in_ready low.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 8 and a power of two.
- BAD_RESULT, 32'hDEADBEEF: result for unsupported func, truncated/zero-extended to WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- operand_a  in  WIDTH  first operand / dividend / shift source
- operand_b  in  WIDTH  second operand / divisor
- shamt  in  log2(WIDTH)  shift amount for sll/srl/sra
- func  in  6  MIPS function code
- out_valid  out  1  one-cycle pulse, result valid
- result  out  WIDTH  registered result, held until next out_valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: async on rst_n low. State=IDLE; result, hi, lo=0; out_valid=0; in_ready=1. No operation survives reset; a mid-operation multiply/divide is discarded.
- Acceptance: at a rising edge with in_valid & in_ready. Inputs are sampled only then and need not be held afterwards.
- FSM states: IDLE, MUL, DIV. No output backpressure; the consumer must take out_valid when it pulses.
- Single-cycle ops (IDLE->IDLE): result registered at the acceptance edge; out_valid=1 the following cycle; latency 1. Back-to-back acceptance every cycle is allowed.
  - 32 add, 34 sub: modulo 2^WIDTH, no overflow trap.
  - 36 and, 37 or, 38 xor, 39 nor (~(a|b)).
  - 0 sll, 2 srl, 3 sra: operand_b shifted by shamt; sra sign-fills.
  - 16 mfhi: result=hi. 18 mflo: result=lo.
- Undefined func: result=BAD_RESULT, out_valid pulses, latency 1, hi/lo unchanged.
- 24 mult / 25 multu (IDLE->MUL):
  - Shift-add over operand magnitudes, one bit per cycle, WIDTH iterations.
  - Signed case negates the 2*WIDTH product when operand signs differ.
  - On the last iteration: {hi,lo}=product, result=lo, FSM->IDLE, out_valid next cycle.
  - Latency WIDTH+1 cycles from acceptance to out_valid; in_ready=0 during MUL.
- 26 div / 27 divu (IDLE->DIV):
  - Restoring divide over magnitudes, WIDTH iterations; lo=quotient, hi=remainder, result=lo. Latency WIDTH+1.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative / -1: lo=most-negative, hi=0.
  - Divisor 0: no iteration; hi=operand_a, lo=all ones, result=all ones, latency 1, stays IDLE.
- in_valid while in_ready=0: ignored; requester must hold the request until accepted.
- hi/lo change only on mult/multu/div/divu completion (or reset); all other ops leave them untouched.
- out_valid is never high in two consecutive cycles when a multi-cycle op is in flight.

Test Plan:
- Reset, then add 7+5, sub 3-5, xor F0F0F0F0^0FF00FF0 on consecutive cycles -> out_valid on 3 consecutive cycles; results 12, FFFFFFFE, FF00FF00; in_ready always 1.
- sra operand_b=80000000, shamt=4 -> F8000000; srl same -> 08000000; func=1 -> DEADBEEF, hi/lo unchanged.
- mult FFFFFFFE (-2) x 00000003 -> in_ready low 32 cycles, out_valid 33 cycles after accept; hi=FFFFFFFF, lo=FFFFFFFA. multu same operands -> hi=00000002, lo=FFFFFFFA.
- div FFFFFFF9 (-7) / 2 -> lo=FFFFFFFD, hi=FFFFFFFF. divu 7/0 -> 1-cycle latency, lo=FFFFFFFF, hi=7. div 80000000/FFFFFFFF -> lo=80000000, hi=0. Then mfhi/mflo return the stored values.
- Hold in_valid with add during a mult -> add accepted the cycle in_ready rises; its result appears the cycle after the mult's out_valid.
- Deassert rst_n at cycle 10 of a divide -> hi, lo, result=0, in_ready=1 immediately; no out_valid for the aborted op; the next add completes normally.
